// File: rtl/als_pkg.sv
// -----------------------------------------------------------------------------
// als_pkg
// Shared constants and state encoding for the PmodALS light-sensor SPI link.
// Used by the responder (ADC emulator) and by the reader side.
//   ALS_DATA_WIDTH  : light value width carried per frame
//   ALS_LEAD_ZEROS  : zero bits sent ahead of the data MSB
//   ALS_FRAME_BITS  : sck rising edges in a complete frame
//   als_resp_state_e: responder frame state (IDLE / ACTIVE)
// -----------------------------------------------------------------------------
package als_pkg;

  localparam int ALS_DATA_WIDTH = 8;
  localparam int ALS_LEAD_ZEROS = 3;
  localparam int ALS_FRAME_BITS = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } als_resp_state_e;

endpackage

// File: rtl/als_sig_sync.sv
// -----------------------------------------------------------------------------
// als_sig_sync
// Multi-flop synchronizer for an idle-high pin plus edge detector.
// Ports:
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset (all stages go to 1)
//   pin_i   : asynchronous pin input
//   level_o : synchronized level (last synchronizer stage)
//   rise_o  : one-cycle strobe on a synchronized 0->1 transition
//   fall_o  : one-cycle strobe on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module als_sig_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;
  logic             prev_q;
  logic             prev_d;

  // Next values: shift the pin into the chain, keep a copy of the last stage.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], pin_i};
    prev_d = sync_q[DEPTH-1];
  end

  // Synchronizer and edge-history flops; reset to the idle-high level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {DEPTH{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[DEPTH-1];
  assign rise_o  = sync_q[DEPTH-1] & ~prev_q;
  assign fall_o  = ~sync_q[DEPTH-1] & prev_q;

endmodule

// File: rtl/als_spi_responder.sv
// -----------------------------------------------------------------------------
// als_spi_responder
// Emulates the PmodALS ADC (ADC081S021 frame format): serializes a light value
// onto sdo in response to the reader's cs/sck. All pins are oversampled by
// clk_i; nothing is clocked by sck.
// Ports:
//   clk_i, rst_i      : system clock, asynchronous active-high reset
//   value_i           : light value, sampled at frame start (cs fall)
//   cs_i, sck_i       : SPI chip select (active-low) and clock from the reader
//   sdo_o, sdo_oe_o   : serial data and its output enable
//   busy_o            : frame active
//   done_o / short_o  : one-cycle pulse at frame end, complete / truncated
// Optional build macro ALS_RESP_STATS_EN adds:
//   frames_o, errors_o: wrapping 16-bit counts of done_o / short_o pulses
// -----------------------------------------------------------------------------
module als_spi_responder
  import als_pkg::*;
#(
  parameter int DATA_WIDTH  = ALS_DATA_WIDTH,
  parameter int LEAD_ZEROS  = ALS_LEAD_ZEROS,
  parameter int FRAME_BITS  = ALS_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic                  cs_i,
  input  logic                  sck_i,
  output logic                  sdo_o,
  output logic                  sdo_oe_o,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef ALS_RESP_STATS_EN
  output logic [15:0]           frames_o,
  output logic [15:0]           errors_o,
`endif
  output logic                  short_o
);

  localparam int TRAIL_BITS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;

  als_resp_state_e state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, load_s;
  logic [CNT_W-1:0]      rise_cnt_q, rise_cnt_d;
  logic pending_q, pending_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic short_q, short_d;

  als_sig_sync #(.DEPTH(SYNC_STAGES)) u_cs_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (cs_i),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  als_sig_sync #(.DEPTH(SYNC_STAGES)) u_sck_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (sck_i),
    .level_o (sck_lvl),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // Frame image: leading zeros, value MSB-first, trailing zeros.
  assign load_s = {{(FRAME_BITS-DATA_WIDTH){1'b0}}, value_i} << TRAIL_BITS;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a frame is bracketed by synchronized cs edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic. cs rise is tested first so a coincident sck edge
  // is dropped. A fall only shifts after a rise (pending), which makes the
  // frame independent of the sck idle level.
  always_comb begin
    shift_d    = shift_q;
    rise_cnt_d = rise_cnt_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    short_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shift_d    = load_s;
          rise_cnt_d = '0;
          pending_d  = 1'b0;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          shift_d    = '0;
          rise_cnt_d = '0;
          pending_d  = 1'b0;
          busy_d     = 1'b0;
          if (rise_cnt_q == CNT_FULL) begin
            done_d  = 1'b1;
          end else begin
            short_d = 1'b1;
          end
        end else if (sck_rise && !cs_lvl) begin
          if (rise_cnt_q != CNT_FULL) begin
            rise_cnt_d = rise_cnt_q + CNT_W'(1);
          end else begin
            rise_cnt_d = rise_cnt_q;
          end
          pending_d = 1'b1;
        end else if (sck_fall && !sck_lvl && pending_q) begin
          shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
          pending_d = 1'b0;
        end else begin
          pending_d = pending_q;
        end
      end
      default: begin
        shift_d    = '0;
        rise_cnt_d = '0;
        pending_d  = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Datapath and registered status flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q    <= '0;
      rise_cnt_q <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      rise_cnt_q <= rise_cnt_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      short_q    <= short_d;
    end
  end

  assign sdo_o    = shift_q[FRAME_BITS-1];
  assign sdo_oe_o = busy_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign short_o  = short_q;

`ifdef ALS_RESP_STATS_EN
  logic [15:0] frames_q, frames_d;
  logic [15:0] errors_q, errors_d;

  // Frame statistics: count completed and truncated frames, wrapping.
  always_comb begin
    frames_d = frames_q;
    errors_d = errors_q;
    if (done_d) begin
      frames_d = frames_q + 16'd1;
    end else begin
      frames_d = frames_q;
    end
    if (short_d) begin
      errors_d = errors_q + 16'd1;
    end else begin
      errors_d = errors_q;
    end
  end

  // Statistics counter flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frames_q <= 16'd0;
      errors_q <= 16'd0;
    end else begin
      frames_q <= frames_d;
      errors_q <= errors_d;
    end
  end

  assign frames_o = frames_q;
  assign errors_o = errors_q;
`endif

endmodule

// File: tb/tb_als_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_als_spi_responder
// Self-checking bench: a behavioural SPI reader drives cs/sck and captures sdo
// on each sck rising edge; expected bits and pulses come from the frame rule
// (3 zeros, value MSB-first, zeros) and the rise count versus 16.
// Define ALS_RESP_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_als_spi_responder;

  localparam int SYNC  = 2;
  localparam int FBITS = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] value_i = 8'h00;
  logic       cs_i = 1'b1;
  logic       sck_i = 1'b1;
  logic       sdo_o, sdo_oe_o, busy_o, done_o, short_o;
`ifdef ALS_RESP_STATS_EN
  logic [15:0] frames_o, errors_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int short_cnt = 0;

  als_spi_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .value_i  (value_i),
    .cs_i     (cs_i),
    .sck_i    (sck_i),
    .sdo_o    (sdo_o),
    .sdo_oe_o (sdo_oe_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
`ifdef ALS_RESP_STATS_EN
    .frames_o (frames_o),
    .errors_o (errors_o),
`endif
    .short_o  (short_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse monitors; a pulse longer than one cycle counts more than once.
  always @(negedge clk_i) begin
    if (done_o)  done_cnt  <= done_cnt + 1;
    if (short_o) short_cnt <= short_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Reference: bit i of the serial stream for a given value.
  function automatic logic [31:0] ref_bits(input logic [7:0] val, input int nrise);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < nrise; i++) begin
      if (i >= 3 && i < 11) r[i] = val[10-i];
      else                  r[i] = 1'b0;
    end
    return r;
  endfunction

  // One reader frame with nrise sck rising edges. With simul_end the final
  // extra rising edge coincides with the cs rise and must be discarded.
  task automatic run_frame(input logic [7:0] val, input int nrise, input bit idle_hi,
                           input int half, input bit simul_end);
    logic [31:0] cap;
    int d0, s0;
    cap = 32'd0;
    sck_i   = idle_hi;
    value_i = val;
    wait_cyc(8);
    d0 = done_cnt;
    s0 = short_cnt;
    cs_i = 1'b0;
    wait_cyc(6);
    chk("busy_start", {31'd0, busy_o}, 32'd1);
    chk("oe_start", {31'd0, sdo_oe_o}, 32'd1);
    value_i = 8'($urandom);
    for (int i = 0; i < nrise; i++) begin
      if (idle_hi) begin
        sck_i = 1'b0; wait_cyc(half);
        cap[i] = sdo_o;
        sck_i = 1'b1; wait_cyc(half);
      end else begin
        cap[i] = sdo_o;
        sck_i = 1'b1; wait_cyc(half);
        sck_i = 1'b0; wait_cyc(half);
      end
    end
    if (simul_end) begin
      sck_i = 1'b0; wait_cyc(half);
      cs_i  = 1'b1;
      sck_i = 1'b1;
    end else begin
      cs_i = 1'b1;
    end
    wait_cyc(SYNC + 1);
    chk("busy_end", {31'd0, busy_o}, 32'd0);
    chk("oe_end", {31'd0, sdo_oe_o}, 32'd0);
    chk("sdo_end", {31'd0, sdo_o}, 32'd0);
    wait_cyc(4);
    chk("bits", cap, ref_bits(val, nrise));
    chk("done_pulses", 32'(done_cnt - d0), (nrise >= FBITS) ? 32'd1 : 32'd0);
    chk("short_pulses", 32'(short_cnt - s0), (nrise < FBITS) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int d0, s0;
    wait_cyc(2);
    chk("rst_sdo", {31'd0, sdo_o}, 32'd0);
    chk("rst_oe", {31'd0, sdo_oe_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_short", {31'd0, short_o}, 32'd0);
    rst_i = 1'b0;
    wait_cyc(4);

    run_frame(8'hA5, 16, 1'b1, 6, 1'b0);
    run_frame(8'h00, 16, 1'b1, 5, 1'b0);
    run_frame(8'hFF, 16, 1'b1, 5, 1'b0);
    run_frame(8'h3C, 9, 1'b1, 6, 1'b0);
    run_frame(8'h81, 20, 1'b1, 4, 1'b0);
    run_frame(8'hC3, 16, 1'b0, 4, 1'b0);
    run_frame(8'h96, 15, 1'b1, 5, 1'b1);

    // Reset in the middle of a frame, while sdo carries a 1.
    sck_i = 1'b1; value_i = 8'hFF;
    wait_cyc(8);
    d0 = done_cnt; s0 = short_cnt;
    cs_i = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 7; i++) begin
      sck_i = 1'b0; wait_cyc(5);
      sck_i = 1'b1; wait_cyc(5);
    end
    sck_i = 1'b0; wait_cyc(5);
    chk("pre_rst_sdo", {31'd0, sdo_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_sdo", {31'd0, sdo_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_oe", {31'd0, sdo_oe_o}, 32'd0);
    cs_i = 1'b1; sck_i = 1'b1;
    wait_cyc(2);
    rst_i = 1'b0;
    wait_cyc(6);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_no_short", 32'(short_cnt - s0), 32'd0);
    run_frame(8'h5A, 16, 1'b1, 6, 1'b0);

    // Randomized frames: value, length, sck idle level and speed.
    for (int k = 0; k < 12; k++) begin
      run_frame(8'($urandom), int'($urandom_range(0, 20)), 1'($urandom),
                int'($urandom_range(4, 8)), 1'b0);
    end

`ifdef ALS_RESP_STATS_EN
    chk("frames_cnt", {16'd0, frames_o}, 32'(done_cnt));
    chk("errors_cnt", {16'd0, errors_o}, 32'(short_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
